rx_tlp_trigger_sched: RTL and testbench



---
 rtl/rx_tlp_trigger_sched_pkg.sv | 20 ++
 rtl/rx_idle_timer.sv | 32 +++
 rtl/rx_tlp_trigger_sched.sv | 186 ++++++++++++++++++
 tb/tb_rx_tlp_trigger_sched.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/rx_tlp_trigger_sched_pkg.sv
// Shared definitions for the rx trigger scheduler: FSM state encodings
// and the default TLP / huge-page sizing.
package rx_tlp_trigger_sched_pkg;

  // Largest write TLP payload in qwords (128 B).
  localparam int RX_MAX_QW = 16;

  // Default huge-page size in qwords (2 MB).
  localparam int RX_HP_QWORDS_DEFAULT = 262144;

  // One-hot scheduler states.
  typedef enum logic [4:0] {
    ST_NO_PAGE  = 5'b00001,
    ST_IDLE     = 5'b00010,
    ST_REQ_TLP  = 5'b00100,
    ST_REQ_LAST = 5'b01000,
    ST_REQ_CHG  = 5'b10000
  } rx_state_e;

endpackage : rx_tlp_trigger_sched_pkg

// File: rtl/rx_idle_timer.sv
// Saturating idle counter. Clear has priority over enable; once the count
// reaches LIMIT it holds there and o_sat stays high until cleared.
module rx_idle_timer #(
  parameter int LIMIT = 1024
) (
  input  logic clk,
  input  logic reset,
  input  logic i_en,
  input  logic i_clr,
  output logic o_sat
);

  localparam int CW = $clog2(LIMIT + 1);

  logic [CW-1:0] r_count;
  logic          w_sat;

  assign w_sat = (r_count == CW'(LIMIT));
  assign o_sat = w_sat;

  // Count up while enabled, stop at LIMIT, drop to zero on clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en && !w_sat) begin
      r_count <= r_count + CW'(1);
    end
  end

endmodule : rx_idle_timer

// File: rtl/rx_tlp_trigger_sched.sv
// Receive-path TLP scheduler: decides when committed rx-buffer data is
// pushed to host memory, how many qwords go into each write TLP, and when
// the current huge page is closed. Owns the rx-buffer read pointer and the
// remaining-space count of the current page. One request outstanding at a time.
module rx_tlp_trigger_sched
  import rx_tlp_trigger_sched_pkg::*;
#(
  parameter int AW            = 10,
  parameter int MAX_QW        = RX_MAX_QW,
  parameter int HP_QWORDS     = RX_HP_QWORDS_DEFAULT,
  parameter int TIMEOUT       = 1024,
  parameter int CLOSE_TIMEOUT = 65536
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW:0]   commited_wr_addr,
  input  logic          hp_grant,
  output logic          hp_consumed,
  output logic          trigger_tlp,
  input  logic          trigger_tlp_ack,
  output logic          send_last_tlp,
  output logic          change_huge_page,
  input  logic          change_huge_page_ack,
  output logic [4:0]    qwords_to_send,
  output logic [AW:0]   commited_rd_addr,
  output logic          busy
);

  // Pointer width includes the wrap bit; AW >= 4 so a 5-bit slice exists.
  localparam int PW = AW + 1;
  // Page-space counter must hold HP_QWORDS itself (HP_QWORDS >= 16).
  localparam int HW = $clog2(HP_QWORDS + 1);

  rx_state_e       r_state;
  logic [PW-1:0]   r_rd_addr;
  logic [HW-1:0]   r_hp_left;
  logic [4:0]      r_qwords;
  logic            r_trigger;
  logic            r_send_last;
  logic            r_change;
  logic            r_hp_consumed;
  logic            r_busy;

  logic [PW-1:0]   w_pending;
  logic            w_pend_zero;
  logic            w_pend_ge_max;
  logic [4:0]      w_n_pend;
  logic            w_hp_limits;
  logic [4:0]      w_n;
  logic            w_n_is_last;
  logic            w_page_used;
  logic            w_in_idle;
  logic            w_tlp_cnt_en;
  logic            w_close_cnt_en;
  logic            w_tlp_timeout;
  logic            w_close_timeout;

  // Modular subtraction handles pointer wrap; a full buffer gives 2^AW.
  assign w_pending     = commited_wr_addr - r_rd_addr;
  assign w_pend_zero   = (w_pending == '0);
  assign w_pend_ge_max = (w_pending >= PW'(MAX_QW));

  // n = min(pending, MAX_QW, hp_left); the TLP that empties the page is the last one.
  assign w_n_pend    = w_pend_ge_max ? 5'(MAX_QW) : w_pending[4:0];
  assign w_hp_limits = (r_hp_left < HW'(w_n_pend));
  assign w_n         = w_hp_limits ? r_hp_left[4:0] : w_n_pend;
  assign w_n_is_last = (HW'(w_n) == r_hp_left);
  assign w_page_used = (r_hp_left < HW'(HP_QWORDS));

  // Timers only run while idling in the condition they measure.
  assign w_in_idle      = (r_state == ST_IDLE);
  assign w_tlp_cnt_en   = w_in_idle && !w_pend_zero && !w_pend_ge_max;
  assign w_close_cnt_en = w_in_idle && w_pend_zero && w_page_used;

  rx_idle_timer #(
    .LIMIT (TIMEOUT)
  ) u_tlp_timer (
    .clk   (clk),
    .reset (reset),
    .i_en  (w_tlp_cnt_en),
    .i_clr (!w_tlp_cnt_en),
    .o_sat (w_tlp_timeout)
  );

  rx_idle_timer #(
    .LIMIT (CLOSE_TIMEOUT)
  ) u_close_timer (
    .clk   (clk),
    .reset (reset),
    .i_en  (w_close_cnt_en),
    .i_clr (!w_close_cnt_en),
    .o_sat (w_close_timeout)
  );

  // Scheduler FSM with registered request, size, pointer and page-space outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= ST_NO_PAGE;
      r_rd_addr     <= '0;
      r_hp_left     <= '0;
      r_qwords      <= '0;
      r_trigger     <= 1'b0;
      r_send_last   <= 1'b0;
      r_change      <= 1'b0;
      r_hp_consumed <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      r_hp_consumed <= 1'b0;
      case (r_state)
        ST_NO_PAGE: begin
          if (hp_grant) begin
            r_hp_left <= HW'(HP_QWORDS);
            r_state   <= ST_IDLE;
          end
        end
        ST_IDLE: begin
          if (w_pend_ge_max || (!w_pend_zero && w_tlp_timeout)) begin
            r_qwords <= w_n;
            r_busy   <= 1'b1;
            if (w_n_is_last) begin
              r_send_last <= 1'b1;
              r_state     <= ST_REQ_LAST;
            end else begin
              r_trigger <= 1'b1;
              r_state   <= ST_REQ_TLP;
            end
          end else if (w_pend_zero && w_page_used && w_close_timeout) begin
            r_qwords <= '0;
            r_busy   <= 1'b1;
            r_change <= 1'b1;
            r_state  <= ST_REQ_CHG;
          end
        end
        ST_REQ_TLP: begin
          if (trigger_tlp_ack) begin
            r_trigger <= 1'b0;
            r_busy    <= 1'b0;
            r_rd_addr <= r_rd_addr + PW'(r_qwords);
            r_hp_left <= r_hp_left - HW'(r_qwords);
            r_qwords  <= '0;
            r_state   <= ST_IDLE;
          end
        end
        ST_REQ_LAST: begin
          if (change_huge_page_ack) begin
            r_send_last   <= 1'b0;
            r_busy        <= 1'b0;
            r_rd_addr     <= r_rd_addr + PW'(r_qwords);
            r_hp_left     <= '0;
            r_qwords      <= '0;
            r_hp_consumed <= 1'b1;
            r_state       <= ST_NO_PAGE;
          end
        end
        ST_REQ_CHG: begin
          if (change_huge_page_ack) begin
            r_change      <= 1'b0;
            r_busy        <= 1'b0;
            r_hp_left     <= '0;
            r_hp_consumed <= 1'b1;
            r_state       <= ST_NO_PAGE;
          end
        end
        default: begin
          // Illegal encoding: park with no page and no request.
          r_trigger   <= 1'b0;
          r_send_last <= 1'b0;
          r_change    <= 1'b0;
          r_busy      <= 1'b0;
          r_qwords    <= '0;
          r_hp_left   <= '0;
          r_state     <= ST_NO_PAGE;
        end
      endcase
    end
  end

  assign hp_consumed      = r_hp_consumed;
  assign trigger_tlp      = r_trigger;
  assign send_last_tlp    = r_send_last;
  assign change_huge_page = r_change;
  assign qwords_to_send   = r_qwords;
  assign commited_rd_addr = r_rd_addr;
  assign busy             = r_busy;

endmodule : rx_tlp_trigger_sched

// File: tb/tb_rx_tlp_trigger_sched.sv
// Directed bench for rx_tlp_trigger_sched: a table of write-pointer moves with
// the expected request kind, size, latency and resulting read pointer, plus
// hand sequences for no-page idling, ignored acks and reset mid-request.
module tb_rx_tlp_trigger_sched;

  localparam int AW     = 6;
  localparam int PW     = AW + 1;
  localparam int MAXQ   = 16;
  localparam int HPQ    = 32;
  localparam int TO     = 20;
  localparam int CTO    = 40;
  localparam int W_FULL = 1;        // decision straight away, request next cycle
  localparam int W_TO   = TO + 1;   // timer saturates, then request next cycle
  localparam int W_CL   = CTO + 1;
  localparam int K_TLP  = 1;        // {change, last, trigger}
  localparam int K_LAST = 2;
  localparam int K_CHG  = 4;
  localparam int NV     = 17;
  localparam int BOUND  = 200;

  logic          clk = 1'b0;
  logic          reset;
  logic [PW-1:0] wr;
  logic          hp_grant;
  logic          hp_consumed;
  logic          trigger_tlp;
  logic          trigger_tlp_ack;
  logic          send_last_tlp;
  logic          change_huge_page;
  logic          change_huge_page_ack;
  logic [4:0]    qwords_to_send;
  logic [PW-1:0] rd;
  logic          busy;

  int total = 0;
  int bad   = 0;

  typedef struct {
    bit   grant;   // pulse hp_grant before moving wr
    int   wr;      // new write pointer
    int   kind;    // expected request
    int   qw;      // expected qwords_to_send
    int   wt;      // expected cycles from wr move to request visible
    int   rd;      // expected read pointer after ack
    bit   cons;    // expected hp_consumed after ack
  } vec_t;

  vec_t vecs [NV];

  rx_tlp_trigger_sched #(
    .AW            (AW),
    .MAX_QW        (MAXQ),
    .HP_QWORDS     (HPQ),
    .TIMEOUT       (TO),
    .CLOSE_TIMEOUT (CTO)
  ) dut (
    .clk                  (clk),
    .reset                (reset),
    .commited_wr_addr     (wr),
    .hp_grant             (hp_grant),
    .hp_consumed          (hp_consumed),
    .trigger_tlp          (trigger_tlp),
    .trigger_tlp_ack      (trigger_tlp_ack),
    .send_last_tlp        (send_last_tlp),
    .change_huge_page     (change_huge_page),
    .change_huge_page_ack (change_huge_page_ack),
    .qwords_to_send       (qwords_to_send),
    .commited_rd_addr     (rd),
    .busy                 (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [2:0] req_kind();
    return {change_huge_page, send_last_tlp, trigger_tlp};
  endfunction

  task automatic check_idle_outputs(input string tag);
    check({tag, "_trig"}, 32'(trigger_tlp), 0);
    check({tag, "_last"}, 32'(send_last_tlp), 0);
    check({tag, "_chg"},  32'(change_huge_page), 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_cons"}, 32'(hp_consumed), 0);
    check({tag, "_qw"},   32'(qwords_to_send), 0);
    check({tag, "_rd"},   32'(rd), 0);
  endtask

  initial begin
    int  cyc;
    bit  got;
    bit  seen;
    logic [2:0] k;
    logic [4:0] qw_hold;

    //             grant wr   kind    qw  wait    rd  cons
    vecs[0]  = '{1'b1, 20,  K_TLP,  16, W_FULL, 16,  1'b0};
    vecs[1]  = '{1'b0, 20,  K_TLP,  4,  W_TO,   20,  1'b0};  // hp_left -> 12
    vecs[2]  = '{1'b0, 36,  K_LAST, 12, W_FULL, 32,  1'b1};  // limited by page
    vecs[3]  = '{1'b1, 36,  K_TLP,  4,  W_TO,   36,  1'b0};
    vecs[4]  = '{1'b0, 36,  K_CHG,  0,  W_CL,   36,  1'b1};  // close empty page
    vecs[5]  = '{1'b1, 84,  K_TLP,  16, W_FULL, 52,  1'b0};
    vecs[6]  = '{1'b0, 84,  K_LAST, 16, W_FULL, 68,  1'b1};
    vecs[7]  = '{1'b1, 84,  K_TLP,  16, W_FULL, 84,  1'b0};
    vecs[8]  = '{1'b0, 100, K_LAST, 16, W_FULL, 100, 1'b1};
    vecs[9]  = '{1'b1, 116, K_TLP,  16, W_FULL, 116, 1'b0};
    vecs[10] = '{1'b0, 4,   K_LAST, 16, W_FULL, 4,   1'b1};  // wr wrapped
    vecs[11] = '{1'b1, 68,  K_TLP,  16, W_FULL, 20,  1'b0};  // full buffer
    vecs[12] = '{1'b0, 68,  K_LAST, 16, W_FULL, 36,  1'b1};
    vecs[13] = '{1'b1, 68,  K_TLP,  16, W_FULL, 52,  1'b0};
    vecs[14] = '{1'b0, 60,  K_TLP,  8,  W_TO,   60,  1'b0};
    vecs[15] = '{1'b0, 62,  K_TLP,  2,  W_TO,   62,  1'b0};  // hp_left -> 6
    vecs[16] = '{1'b0, 72,  K_LAST, 6,  W_TO,   68,  1'b1};  // timeout + page end

    reset                = 1'b1;
    wr                   = '0;
    hp_grant             = 1'b0;
    trigger_tlp_ack      = 1'b0;
    change_huge_page_ack = 1'b0;
    step();
    step();
    check_idle_outputs("rst");
    reset = 1'b0;
    step();
    check_idle_outputs("post_rst");

    // Without a page nothing may be requested, however long data waits.
    wr   = PW'(20);
    seen = 1'b0;
    for (int c = 0; c < 3 * TO; c++) begin
      step();
      if (req_kind() != 3'b000 || busy) seen = 1'b1;
    end
    check("no_page_req", 32'(seen), 0);

    for (int i = 0; i < NV; i++) begin
      if (vecs[i].grant) begin
        hp_grant = 1'b1;
        step();
        hp_grant = 1'b0;
      end
      wr  = PW'(vecs[i].wr);
      cyc = 0;
      got = 1'b0;
      while (cyc < BOUND && !got) begin
        step();
        cyc++;
        if (req_kind() != 3'b000) got = 1'b1;
      end
      k = req_kind();
      $display("txn %0d: wr=%0d kind=%0d qw=%0d wait=%0d", i, vecs[i].wr, k, qwords_to_send, cyc);
      check($sformatf("v%0d_kind", i), 32'(k), 32'(vecs[i].kind));
      if (got) begin
        check($sformatf("v%0d_qw", i),   32'(qwords_to_send), 32'(vecs[i].qw));
        check($sformatf("v%0d_wait", i), 32'(cyc), 32'(vecs[i].wt));
        check($sformatf("v%0d_busy", i), 32'(busy), 1);
        if (vecs[i].kind == K_TLP) trigger_tlp_ack = 1'b1;
        else change_huge_page_ack = 1'b1;
        step();
        trigger_tlp_ack      = 1'b0;
        change_huge_page_ack = 1'b0;
        check($sformatf("v%0d_drop", i), 32'(req_kind()), 0);
        check($sformatf("v%0d_idle", i), 32'(busy), 0);
        check($sformatf("v%0d_rd", i),   32'(rd), 32'(vecs[i].rd));
        check($sformatf("v%0d_cons", i), 32'(hp_consumed), 32'(vecs[i].cons));
      end
    end

    // Wrong-kind ack is ignored and the request stays stable.
    hp_grant = 1'b1;
    step();
    hp_grant = 1'b0;
    wr = PW'(88);
    step();
    check("hold_trig", 32'(trigger_tlp), 1);
    check("hold_qw", 32'(qwords_to_send), 16);
    qw_hold = qwords_to_send;
    change_huge_page_ack = 1'b1;
    step();
    change_huge_page_ack = 1'b0;
    step();
    step();
    $display("txn hold: kind=%0d qw=%0d rd=%0d", req_kind(), qwords_to_send, rd);
    check("wrong_ack_trig", 32'(trigger_tlp), 1);
    check("wrong_ack_rd", 32'(rd), 68);
    check("wrong_ack_qw", 32'(qwords_to_send), 32'(qw_hold));
    check("wrong_ack_cons", 32'(hp_consumed), 0);

    // Reset mid-request clears everything at once, not at the next edge.
    #2;
    reset = 1'b1;
    #1;
    check_idle_outputs("mid_rst");
    wr = '0;
    step();
    reset = 1'b0;
    trigger_tlp_ack = 1'b1;
    step();
    trigger_tlp_ack = 1'b0;
    step();
    $display("txn stale_ack: kind=%0d rd=%0d busy=%0d", req_kind(), rd, busy);
    check_idle_outputs("stale_ack");
    wr   = PW'(20);
    seen = 1'b0;
    for (int c = 0; c < 2 * TO; c++) begin
      step();
      if (req_kind() != 3'b000) seen = 1'b1;
    end
    check("post_rst_no_page", 32'(seen), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_rx_tlp_trigger_sched
